// File: rtl/bilinear_scheduler.sv
// Bilinear resampler read-address and coefficient scheduler.
// Define BILINEAR_EDGE_CLAMP_EN to clamp read addresses to the source edge.
module bilinear_scheduler #(
    parameter int CW = 16,
    parameter int FW = 16
) (
    input  logic          vin_clk,
    input  logic          rst,
    input  logic          frame_sync_n,
    input  logic          start,
    input  logic [CW-1:0] src_w,
    input  logic [CW-1:0] src_h,
    input  logic [CW-1:0] dst_w,
    input  logic [CW-1:0] dst_h,
    input  logic [31:0]   step_x,
    input  logic [31:0]   step_y,
    input  logic [CW-1:0] line_avail,
    input  logic          hold,
    output logic          rd_en,
    output logic [CW-1:0] rd_x0,
    output logic [CW-1:0] rd_x1,
    output logic [CW-1:0] rd_y0,
    output logic [CW-1:0] rd_y1,
    output logic          coo_valid,
    output logic [FW:0]   coefficient1,
    output logic [FW:0]   coefficient2,
    output logic [FW:0]   coefficient3,
    output logic [FW:0]   coefficient4,
    output logic [CW-1:0] vout_t_x,
    output logic [CW-1:0] vout_t_y,
    output logic          busy,
    output logic          frame_done
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_LINE,
        RUN,
        DONE
    } state_t;

    localparam logic [FW:0] ONE = {1'b1, {FW{1'b0}}};

    state_t        state_q;
    state_t        state_d;
    logic          issue;

    logic [CW-1:0] src_w_q;
    logic [CW-1:0] src_h_q;
    logic [CW-1:0] dst_w_q;
    logic [CW-1:0] dst_h_q;
    logic [31:0]   step_x_q;
    logic [31:0]   step_y_q;
    logic [31:0]   acc_x;
    logic [31:0]   acc_y;
    logic [CW-1:0] out_x;
    logic [CW-1:0] out_y;

    logic [CW-1:0] x0_raw;
    logic [CW-1:0] y0_raw;
    logic [CW-1:0] x0;
    logic [CW-1:0] x1;
    logic [CW-1:0] y0;
    logic [CW-1:0] y1;
    logic [FW-1:0] fx;
    logic [FW-1:0] fy;
    logic          last_x;
    logic          last_y;

    assign x0_raw = CW'(acc_x >> FW);
    assign y0_raw = CW'(acc_y >> FW);
    assign fx     = acc_x[FW-1:0];
    assign fy     = acc_y[FW-1:0];

`ifdef BILINEAR_EDGE_CLAMP_EN
    logic [CW-1:0] x_max;
    logic [CW-1:0] y_max;

    assign x_max = src_w_q - CW'(1);
    assign y_max = src_h_q - CW'(1);
    assign x0    = (x0_raw > x_max) ? x_max : x0_raw;
    assign y0    = (y0_raw > y_max) ? y_max : y0_raw;
    assign x1    = (x0_raw >= x_max) ? x_max : x0_raw + CW'(1);
    assign y1    = (y0_raw >= y_max) ? y_max : y0_raw + CW'(1);
`else
    assign x0 = x0_raw;
    assign y0 = y0_raw;
    assign x1 = x0_raw + CW'(1);
    assign y1 = y0_raw + CW'(1);
`endif

    assign last_x = (out_x == dst_w_q - CW'(1));
    assign last_y = (out_y == dst_h_q - CW'(1));

    always_comb begin
        state_d    = state_q;
        issue      = 1'b0;
        frame_done = 1'b0;
        busy       = (state_q != IDLE);
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (dst_w == '0 || dst_h == '0)
                        state_d = DONE;
                    else
                        state_d = WAIT_LINE;
                end
            end
            WAIT_LINE: begin
                if (line_avail > y1)
                    state_d = RUN;
            end
            RUN: begin
                if (!hold) begin
                    issue = 1'b1;
                    if (last_x)
                        state_d = last_y ? DONE : WAIT_LINE;
                end
            end
            DONE: begin
                frame_done = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Abort and reset both kill any read or completion this cycle.
        if (!frame_sync_n || rst) begin
            state_d    = IDLE;
            issue      = 1'b0;
            frame_done = 1'b0;
        end
        rd_en = issue;
        rd_x0 = issue ? x0 : '0;
        rd_x1 = issue ? x1 : '0;
        rd_y0 = issue ? y0 : '0;
        rd_y1 = issue ? y1 : '0;
    end

    always_ff @(posedge vin_clk) begin
        if (rst) begin
            state_q      <= IDLE;
            src_w_q      <= '0;
            src_h_q      <= '0;
            dst_w_q      <= '0;
            dst_h_q      <= '0;
            step_x_q     <= '0;
            step_y_q     <= '0;
            acc_x        <= '0;
            acc_y        <= '0;
            out_x        <= '0;
            out_y        <= '0;
            coo_valid    <= 1'b0;
            coefficient1 <= '0;
            coefficient2 <= '0;
            coefficient3 <= '0;
            coefficient4 <= '0;
            vout_t_x     <= '0;
            vout_t_y     <= '0;
        end else begin
            state_q   <= state_d;
            coo_valid <= issue;
            // Line-buffer read latency is one cycle; weights travel with it.
            if (issue) begin
                coefficient1 <= ONE - {1'b0, fx};
                coefficient2 <= {1'b0, fx};
                coefficient3 <= ONE - {1'b0, fy};
                coefficient4 <= {1'b0, fy};
                vout_t_x     <= out_x;
                vout_t_y     <= out_y;
            end
            if (state_q == IDLE && start && frame_sync_n) begin
                src_w_q  <= src_w;
                src_h_q  <= src_h;
                dst_w_q  <= dst_w;
                dst_h_q  <= dst_h;
                step_x_q <= step_x;
                step_y_q <= step_y;
                acc_x    <= '0;
                acc_y    <= '0;
                out_x    <= '0;
                out_y    <= '0;
            end
            if (state_q == WAIT_LINE) begin
                acc_x <= '0;
                out_x <= '0;
            end
            if (issue) begin
                acc_x <= acc_x + step_x_q;
                out_x <= out_x + CW'(1);
                if (last_x && !last_y) begin
                    acc_y <= acc_y + step_y_q;
                    out_y <= out_y + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_bilinear_scheduler.sv
// Randomized self-checking bench for bilinear_scheduler.
// Reference reads are computed per frame from output coordinates times step.
module tb_bilinear_scheduler;

    logic        vin_clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_sync_n = 1'b1;
    logic        start = 1'b0;
    logic [15:0] src_w = '0, src_h = '0, dst_w = '0, dst_h = '0;
    logic [31:0] step_x = '0, step_y = '0;
    logic [15:0] line_avail = '0;
    logic        hold = 1'b0;
    logic        rd_en;
    logic [15:0] rd_x0, rd_x1, rd_y0, rd_y1;
    logic        coo_valid;
    logic [16:0] coefficient1, coefficient2, coefficient3, coefficient4;
    logic [15:0] vout_t_x, vout_t_y;
    logic        busy, frame_done;

    always #5 vin_clk = ~vin_clk;

    bilinear_scheduler dut (
        .vin_clk(vin_clk), .rst(rst), .frame_sync_n(frame_sync_n),
        .start(start), .src_w(src_w), .src_h(src_h), .dst_w(dst_w),
        .dst_h(dst_h), .step_x(step_x), .step_y(step_y),
        .line_avail(line_avail), .hold(hold), .rd_en(rd_en),
        .rd_x0(rd_x0), .rd_x1(rd_x1), .rd_y0(rd_y0), .rd_y1(rd_y1),
        .coo_valid(coo_valid), .coefficient1(coefficient1),
        .coefficient2(coefficient2), .coefficient3(coefficient3),
        .coefficient4(coefficient4), .vout_t_x(vout_t_x),
        .vout_t_y(vout_t_y), .busy(busy), .frame_done(frame_done)
    );

    typedef struct {
        int x0; int x1; int y0; int y1;
        int fx; int fy; int ox; int oy;
    } rd_t;

    rd_t exp_q[$];
    rd_t rdlog[$];
    int  c2log[$];
    int  vxlog[$];
    rd_t prev_it, cur;
    bit  prev_issue = 0;
    bit  issued;
    int  checks = 0;
    int  errors = 0;
    int  done_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, expv);
        end
    endtask

    // Expected read stream: pixel (ox,oy) samples source at ox*sx, oy*sy.
    task automatic build(input int sw, input int sh, input int dw,
                         input int dh, input logic [31:0] sx,
                         input logic [31:0] sy);
        for (int oy = 0; oy < dh; oy++) begin
            for (int ox = 0; ox < dw; ox++) begin
                logic [31:0] ax, ay;
                rd_t r;
                ax = 32'(ox) * sx;
                ay = 32'(oy) * sy;
                r.fx = int'(ax[15:0]);
                r.fy = int'(ay[15:0]);
`ifdef BILINEAR_EDGE_CLAMP_EN
                r.x0 = (int'(ax[31:16]) < sw - 1) ? int'(ax[31:16]) : sw - 1;
                r.y0 = (int'(ay[31:16]) < sh - 1) ? int'(ay[31:16]) : sh - 1;
                r.x1 = (int'(ax[31:16]) + 1 < sw - 1) ? int'(ax[31:16]) + 1 : sw - 1;
                r.y1 = (int'(ay[31:16]) + 1 < sh - 1) ? int'(ay[31:16]) + 1 : sh - 1;
`else
                r.x0 = int'(ax[31:16]);
                r.y0 = int'(ay[31:16]);
                r.x1 = (r.x0 + 1) % 65536;
                r.y1 = (r.y0 + 1) % 65536;
                if (sw < 0 || sh < 0) r.x1 = 0;
`endif
                r.ox = ox;
                r.oy = oy;
                exp_q.push_back(r);
            end
        end
    endtask

    always @(negedge vin_clk) begin
        chk("coo_valid", coo_valid, prev_issue);
        if (coo_valid === 1'b1 && prev_issue) begin
            chk("coef1", coefficient1, 64'(32'h10000 - prev_it.fx));
            chk("coef2", coefficient2, 64'(prev_it.fx));
            chk("coef3", coefficient3, 64'(32'h10000 - prev_it.fy));
            chk("coef4", coefficient4, 64'(prev_it.fy));
            chk("coef_sum_x", 64'(coefficient1) + 64'(coefficient2), 64'h10000);
            chk("coef_sum_y", 64'(coefficient3) + 64'(coefficient4), 64'h10000);
            chk("vout_x", vout_t_x, 64'(prev_it.ox));
            chk("vout_y", vout_t_y, 64'(prev_it.oy));
            c2log.push_back(int'(coefficient2));
            vxlog.push_back(int'(vout_t_x));
        end
        issued = 0;
        if (rd_en === 1'b1) begin
            chk("rd_en_vs_hold", hold, 0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected got x0=%0h y0=%0h want no read",
                         rd_x0, rd_y0);
            end else begin
                cur = exp_q.pop_front();
                chk("rd_x0", rd_x0, 64'(cur.x0));
                chk("rd_x1", rd_x1, 64'(cur.x1));
                chk("rd_y0", rd_y0, 64'(cur.y0));
                chk("rd_y1", rd_y1, 64'(cur.y1));
                chk("line_ready", int'(line_avail) > cur.y1, 1);
                prev_it = cur;
                issued = 1;
                rdlog.push_back('{int'(rd_x0), int'(rd_x1), int'(rd_y0),
                                  int'(rd_y1), 0, 0, 0, 0});
            end
        end
        prev_issue = issued;
        if (rst || !frame_sync_n) begin
            prev_issue = 0;
            exp_q.delete();
        end
        if (frame_done === 1'b1) done_cnt++;
    end

    task automatic start_frame(input int sw, input int sh, input int dw,
                               input int dh, input logic [31:0] sx,
                               input logic [31:0] sy, input int la);
        build(sw, sh, dw, dh, sx, sy);
        rdlog.delete();
        c2log.delete();
        vxlog.delete();
        src_w = 16'(sw);
        src_h = 16'(sh);
        dst_w = 16'(dw);
        dst_h = 16'(dh);
        step_x = sx;
        step_y = sy;
        line_avail = 16'(la);
        start = 1'b1;
        @(posedge vin_clk);
        #1 start = 1'b0;
    endtask

    task automatic finish_frame(input bit rnd_hold, input bit grow, input int d0);
        bit got = 0;
        for (int c = 0; c < 2000 && !got; c++) begin
            hold = rnd_hold && ($urandom_range(3) == 0);
            if (grow && line_avail < 40 && $urandom_range(1) == 1)
                line_avail = line_avail + 16'd1;
            @(negedge vin_clk);
            if (frame_done === 1'b1) got = 1;
            @(posedge vin_clk);
            #1;
        end
        hold = 1'b0;
        chk("frame_done_seen", got, 1);
        repeat (3) @(posedge vin_clk);
        #1;
        chk("frame_done_once", done_cnt - d0, 1);
        chk("exp_q_empty", exp_q.size(), 0);
        chk("busy_idle", busy, 0);
    endtask

    task automatic wait_rd();
        bit got = 0;
        for (int c = 0; c < 30 && !got; c++) begin
            @(negedge vin_clk);
            if (rd_en === 1'b1) got = 1;
            @(posedge vin_clk);
            #1;
        end
        chk("rd_seen", got, 1);
    endtask

    task automatic check_zero(input string nm);
        @(negedge vin_clk);
        chk({nm, "_rd_en"}, rd_en, 0);
        chk({nm, "_rd_addr"}, {rd_x0, rd_x1, rd_y0, rd_y1}, 0);
        chk({nm, "_coo_valid"}, coo_valid, 0);
        chk({nm, "_coef"}, {coefficient1, coefficient2, coefficient3}, 0);
        chk({nm, "_coef4"}, coefficient4, 0);
        chk({nm, "_vout"}, {vout_t_x, vout_t_y}, 0);
        chk({nm, "_busy_done"}, {busy, frame_done}, 0);
    endtask

    initial begin
        int d0;
        int ex[4];
        int ey[4];
        ex = '{0, 2, 0, 2};
        ey = '{0, 0, 2, 2};
        repeat (2) @(posedge vin_clk);
        #1 rst = 1'b0;
        check_zero("reset");
        @(posedge vin_clk);
        #1;

        // 4x4 -> 2x2, step 2: reads at even source points, zero fraction.
        d0 = done_cnt;
        start_frame(4, 4, 2, 2, 32'h20000, 32'h20000, 4);
        finish_frame(0, 0, d0);
        chk("dec_reads", rdlog.size(), 4);
        for (int i = 0; i < 4 && i < rdlog.size(); i++) begin
            chk("dec_x0", rdlog[i].x0, ex[i]);
            chk("dec_y0", rdlog[i].y0, ey[i]);
            chk("dec_c2", c2log[i], 0);
        end

`ifdef BILINEAR_EDGE_CLAMP_EN
        d0 = done_cnt;
        start_frame(2, 2, 4, 4, 32'h8000, 32'h8000, 10);
        finish_frame(0, 0, d0);
        chk("up_reads", rdlog.size(), 16);
        if (rdlog.size() >= 4) begin
            chk("up_x0_0", rdlog[0].x0, 0);
            chk("up_x0_1", rdlog[1].x0, 0);
            chk("up_x0_2", rdlog[2].x0, 1);
            chk("up_x0_3", rdlog[3].x0, 1);
            chk("up_x1_2", rdlog[2].x1, 1);
            chk("up_c2_1", c2log[1], 32'h8000);
            chk("up_c2_2", c2log[2], 0);
            chk("up_c2_3", c2log[3], 32'h8000);
        end
`endif

        // Line gating: row 0 needs two source rows available.
        d0 = done_cnt;
        start_frame(4, 4, 2, 2, 32'h10000, 32'h10000, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge vin_clk);
            chk("no_rd_early", rd_en, 0);
            @(posedge vin_clk);
            #1;
        end
        line_avail = 16'd2;
        @(negedge vin_clk);
        chk("rd_at_exit", rd_en, 0);
        @(posedge vin_clk);
        #1;
        @(negedge vin_clk);
        chk("rd_first", rd_en, 1);
        @(posedge vin_clk);
        #1 line_avail = 16'd4;
        finish_frame(0, 0, d0);

        // Hold mid-line for three cycles.
        d0 = done_cnt;
        start_frame(8, 2, 4, 1, 32'h10000, 32'h10000, 4);
        wait_rd();
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge vin_clk);
            chk("hold_rd", rd_en, 0);
            @(posedge vin_clk);
            #1;
        end
        hold = 1'b0;
        finish_frame(0, 0, d0);
        chk("hold_pixels", vxlog.size(), 4);
        for (int i = 0; i < 4 && i < vxlog.size(); i++)
            chk("hold_vx", vxlog[i], i);

        // Frame abort mid-RUN, then a clean restart.
        d0 = done_cnt;
        start_frame(8, 8, 4, 2, 32'h10000, 32'h10000, 10);
        wait_rd();
        frame_sync_n = 1'b0;
        @(negedge vin_clk);
        chk("abort_rd", rd_en, 0);
        @(posedge vin_clk);
        #1 frame_sync_n = 1'b1;
        @(negedge vin_clk);
        chk("abort_idle", {busy, coo_valid, frame_done}, 0);
        repeat (3) @(posedge vin_clk);
        #1;
        chk("abort_no_done", done_cnt - d0, 0);
        d0 = done_cnt;
        start_frame(8, 8, 4, 2, 32'h18000, 32'h10000, 10);
        finish_frame(1, 0, d0);
        if (rdlog.size() > 0)
            chk("restart_origin", {rdlog[0].x0, rdlog[0].y0}, 0);

        // Reset mid-RUN, then a zero-size frame.
        start_frame(8, 8, 4, 4, 32'h10000, 32'h10000, 10);
        wait_rd();
        rst = 1'b1;
        @(posedge vin_clk);
        #1 rst = 1'b0;
        check_zero("midrst");
        @(posedge vin_clk);
        #1;
        d0 = done_cnt;
        start_frame(4, 4, 0, 3, 32'h10000, 32'h10000, 4);
        finish_frame(0, 0, d0);
        chk("zero_reads", rdlog.size(), 0);

        // Random frames, including wrapping steps and random hold.
        for (int n = 0; n < 14; n++) begin
            int dw, dh;
            logic [31:0] sx, sy;
            dw = $urandom_range(5);
            dh = $urandom_range(5);
            if (n < 12 && dw == 0) dw = 1;
            sx = ($urandom_range(7) == 0) ? $urandom : $urandom_range(32'h30000, 32'h2000);
            sy = $urandom_range(32'h30000, 32'h2000);
            d0 = done_cnt;
            start_frame($urandom_range(8, 1), $urandom_range(8, 1), dw, dh,
                        sx, sy, $urandom_range(2));
            finish_frame(1, 1, d0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
